// File: rtl/proc_seq_ctrl.sv
// rtl/proc_seq_ctrl.sv - ROM-driven instruction sequencer for the MV/MVI/ADD/SUB datapath processor
module proc_seq_ctrl #(
    parameter int       ADDR_W   = 5,
    parameter logic [2:0] OPC_MVI  = 3'd1,
    parameter logic [2:0] OPC_HALT = 3'd7,
    parameter int       TIMEOUT  = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_addr,
    input  logic              Step_mode,
    input  logic              Step,
    input  logic              Stop,
    output logic [ADDR_W-1:0] Rom_addr,
    input  logic [15:0]       Rom_data,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Timeout_err,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       Instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IMM, S_ISSUE, S_EXEC, S_PAUSE
    } state_t;

    // Last EXEC cycle index before the Done watchdog fires
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [7:0]  tcnt;
    logic        is_mvi;
    logic        tcnt_last;

    assign is_mvi    = (instr[8:6] == OPC_MVI);
    assign tcnt_last = (tcnt == TO_LAST);

    // State register; reset forces IDLE so Run/DIN drop without waiting for a clock
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode; the opcode is inspected straight off the ROM bus in DECODE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (Start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (Rom_data[8:6] == OPC_HALT)     state_nxt = S_IDLE;
                else if (Rom_data[8:6] == OPC_MVI) state_nxt = S_IMM;
                else                               state_nxt = S_ISSUE;
            end
            S_IMM:    state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_EXEC;
            S_EXEC: begin
                if (Done) begin
                    if (Stop)           state_nxt = S_IDLE;
                    else if (Step_mode) state_nxt = S_PAUSE;
                    else                state_nxt = S_FETCH;
                end else if (tcnt_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PAUSE: begin
                if (Stop)      state_nxt = S_IDLE;
                else if (Step) state_nxt = S_FETCH;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from registered state only: ROM address, processor DIN and Run
    always_comb begin
        Rom_addr = PC;
        DIN      = 16'h0000;
        Run      = 1'b0;
        case (state)
            S_DECODE: Rom_addr = PC + ADDR_W'(1);
            S_ISSUE: begin
                DIN = instr;
                Run = 1'b1;
            end
            S_EXEC:   DIN = is_mvi ? imm : instr;
            default:  ;
        endcase
    end

    // Datapath: PC, instruction/immediate latches, Done watchdog, status flags
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PC          <= '0;
            instr       <= 16'h0000;
            imm         <= 16'h0000;
            tcnt        <= 8'd0;
            Instr_count <= 16'h0000;
            Halted      <= 1'b0;
            Timeout_err <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            Busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        PC          <= Start_addr;
                        Instr_count <= 16'h0000;
                        Halted      <= 1'b0;
                        Timeout_err <= 1'b0;
                    end
                end
                S_DECODE: begin
                    instr <= Rom_data;
                    if (Rom_data[8:6] == OPC_HALT) Halted <= 1'b1;
                end
                S_IMM:   imm  <= Rom_data;
                S_ISSUE: tcnt <= 8'd0;
                S_EXEC: begin
                    tcnt <= tcnt + 8'd1;
                    if (Done) begin
                        PC          <= PC + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
                        Instr_count <= Instr_count + 16'd1;
                    end else if (tcnt_last) begin
                        Timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb/tb_proc_seq_ctrl.sv - directed bench for proc_seq_ctrl with ROM and Done responder models
module tb_proc_seq_ctrl;

    localparam int AW = 5;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start = 1'b0;
    logic [AW-1:0] Start_addr = '0;
    logic          Step_mode = 1'b0;
    logic          Step = 1'b0;
    logic          Stop = 1'b0;
    logic          Done = 1'b0;
    logic [AW-1:0] Rom_addr;
    logic [15:0]   Rom_data;
    logic [15:0]   DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Timeout_err;
    logic [AW-1:0] PC;
    logic [15:0]   Instr_count;

    logic [15:0] rom [0:31];
    int n_checks = 0;
    int n_errors = 0;
    bit done_en = 1'b1;
    int done_delay = 0;
    int cd = 0;
    int run_count = 0;
    int r0;

    typedef struct {
        logic        start;
        logic        run;
        logic [15:0] din;
        logic        busy;
        logic        chk_addr;
        logic [4:0]  addr;
    } vec_t;
    vec_t vt [8];

    proc_seq_ctrl #(.ADDR_W(AW), .OPC_MVI(3'd1), .OPC_HALT(3'd7), .TIMEOUT(15)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Start_addr(Start_addr),
        .Step_mode(Step_mode), .Step(Step), .Stop(Stop), .Rom_addr(Rom_addr),
        .Rom_data(Rom_data), .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy),
        .Halted(Halted), .Timeout_err(Timeout_err), .PC(PC), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    // Synchronous ROM: data for an address appears one cycle later
    always @(posedge Clock) Rom_data <= rom[Rom_addr];

    // Processor stand-in: counts Run pulses, raises Done done_delay cycles into EXEC
    always @(negedge Clock) begin
        Done = 1'b0;
        if (Run) begin
            run_count++;
            cd = done_delay + 1;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0 && done_en) Done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_at(input logic [AW-1:0] a);
        Start_addr = a;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (Busy && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (Busy) begin
            n_errors++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles, expected 0", Busy, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

        // Reset values
        repeat (2) tick();
        check("rst_run", 16'(Run), 16'h0);
        check("rst_din", DIN, 16'h0000);
        check("rst_busy", 16'(Busy), 16'h0);
        check("rst_halted", 16'(Halted), 16'h0);
        check("rst_timeout", 16'(Timeout_err), 16'h0);
        check("rst_pc", 16'(PC), 16'h0);
        check("rst_count", Instr_count, 16'h0);
        Resetn = 1'b1;
        tick();

        // MVI R0,#5 then HALT, cycle-by-cycle trace from the Start edge
        rom[0] = 16'h0040; rom[1] = 16'h0005; rom[2] = 16'h01C0;
        done_delay = 0;
        Start_addr = 5'd0;
        vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 5'd0};
        vt[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 5'd1};
        vt[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5'd0};
        vt[3] = '{1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 5'd0};
        vt[4] = '{1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 5'd0};
        vt[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 5'd2};
        vt[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 5'd3};
        vt[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 5'd2};
        for (int i = 0; i < 8; i++) begin
            Start = vt[i].start;
            tick();
            check($sformatf("mvi_c%0d_run", i + 1), 16'(Run), 16'(vt[i].run));
            check($sformatf("mvi_c%0d_din", i + 1), DIN, vt[i].din);
            check($sformatf("mvi_c%0d_busy", i + 1), 16'(Busy), 16'(vt[i].busy));
            if (vt[i].chk_addr)
                check($sformatf("mvi_c%0d_addr", i + 1), 16'(Rom_addr), 16'(vt[i].addr));
        end
        Start = 1'b0;
        check("mvi_pc", 16'(PC), 16'd2);
        check("mvi_halted", 16'(Halted), 16'h1);
        check("mvi_count", Instr_count, 16'd1);

        // ADD with Done three cycles late
        rom[8] = 16'h0081; rom[9] = 16'h01C0;
        done_delay = 3;
        r0 = run_count;
        start_at(5'd8);
        tick(); tick();
        check("add_issue_run", 16'(Run), 16'h1);
        check("add_issue_din", DIN, 16'h0081);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("add_exec%0d_din", k), DIN, 16'h0081);
            check($sformatf("add_exec%0d_run", k), 16'(Run), 16'h0);
        end
        wait_idle(20);
        check("add_runs", 16'(run_count - r0), 16'd1);
        check("add_pc", 16'(PC), 16'd9);
        check("add_count", Instr_count, 16'd1);

        // Single-step through three instructions
        rom[12] = 16'h0001; rom[13] = 16'h0081; rom[14] = 16'h00C1; rom[15] = 16'h01C0;
        done_delay = 0;
        Step_mode = 1'b1;
        r0 = run_count;
        start_at(5'd12);
        repeat (8) tick();
        check("step1_count", Instr_count, 16'd1);
        check("step1_pc", 16'(PC), 16'd13);
        check("step1_runs", 16'(run_count - r0), 16'd1);
        check("step1_busy", 16'(Busy), 16'h1);
        for (int k = 2; k <= 3; k++) begin
            Step = 1'b1;
            tick();
            Step = 1'b0;
            repeat (8) tick();
            check($sformatf("step%0d_count", k), Instr_count, 16'(k));
            check($sformatf("step%0d_pc", k), 16'(PC), 16'(12 + k));
            check($sformatf("step%0d_runs", k), 16'(run_count - r0), 16'(k));
            check($sformatf("step%0d_busy", k), 16'(Busy), 16'h1);
        end
        Step = 1'b1; Stop = 1'b1;
        tick();
        Step = 1'b0; Stop = 1'b0;
        repeat (3) tick();
        check("pause_stop_busy", 16'(Busy), 16'h0);
        check("pause_stop_runs", 16'(run_count - r0), 16'd3);
        check("pause_stop_halted", 16'(Halted), 16'h0);
        Step_mode = 1'b0;

        // Done never arrives: watchdog after 15 EXEC cycles
        rom[16] = 16'h0001; rom[17] = 16'h01C0;
        done_en = 1'b0;
        start_at(5'd16);
        tick(); tick();
        check("to_issue_run", 16'(Run), 16'h1);
        repeat (15) tick();
        check("to_exec15_busy", 16'(Busy), 16'h1);
        check("to_exec15_err", 16'(Timeout_err), 16'h0);
        tick();
        check("to_busy", 16'(Busy), 16'h0);
        check("to_err", 16'(Timeout_err), 16'h1);
        check("to_pc", 16'(PC), 16'd16);
        check("to_count", Instr_count, 16'd0);
        done_en = 1'b1;
        start_at(5'd16);
        check("to_restart_err", 16'(Timeout_err), 16'h0);
        wait_idle(30);
        check("to_restart_pc", 16'(PC), 16'd17);
        check("to_restart_count", Instr_count, 16'd1);

        // MVI at the top address wraps its immediate fetch to address 0
        rom[31] = 16'h0040; rom[0] = 16'h1234; rom[1] = 16'h01C0;
        done_delay = 0;
        start_at(5'd31);
        tick(); tick(); tick();
        check("wrap_issue_run", 16'(Run), 16'h1);
        check("wrap_issue_din", DIN, 16'h0040);
        tick();
        check("wrap_exec_din", DIN, 16'h1234);
        wait_idle(20);
        check("wrap_pc", 16'(PC), 16'd1);
        check("wrap_count", Instr_count, 16'd1);
        check("wrap_halted", 16'(Halted), 16'h1);

        // Stop raised mid-EXEC still lets the instruction finish
        rom[20] = 16'h0081; rom[21] = 16'h0001; rom[22] = 16'h01C0;
        done_delay = 2;
        r0 = run_count;
        start_at(5'd20);
        tick(); tick(); tick();
        Stop = 1'b1;
        tick();
        check("stop_exec_busy", 16'(Busy), 16'h1);
        check("stop_exec_count", Instr_count, 16'd0);
        tick(); tick();
        check("stop_busy", 16'(Busy), 16'h0);
        check("stop_count", Instr_count, 16'd1);
        check("stop_pc", 16'(PC), 16'd21);
        repeat (5) tick();
        check("stop_runs", 16'(run_count - r0), 16'd1);
        Stop = 1'b0;

        // Reset asserted while Run is high
        done_en = 1'b0;
        start_at(5'd21);
        tick(); tick();
        check("rstmid_run_before", 16'(Run), 16'h1);
        Resetn = 1'b0;
        #1;
        check("rstmid_run", 16'(Run), 16'h0);
        check("rstmid_din", DIN, 16'h0000);
        check("rstmid_busy", 16'(Busy), 16'h0);
        check("rstmid_pc", 16'(PC), 16'h0);
        check("rstmid_addr", 16'(Rom_addr), 16'h0);
        tick();
        Resetn = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_seq_ctrl.md
# proc_seq_ctrl

Instruction sequencer that runs the 16-bit datapath processor (MV/MVI/ADD/SUB) autonomously from a synchronous instruction ROM. It fetches each instruction word, prefetches the MVI immediate, drives the processor's DIN/Run inputs with correct phasing, and waits for Done before advancing the program counter. It sits between the program ROM and the processor's DIN/Run/Done pins, replacing manual switch entry. It also provides start, single-step, stop, halt and Done-timeout control.

## Interface
- ADDR_W, 5, ROM address width; PC wraps modulo 2^ADDR_W
- OPC_MVI, 3'd1, opcode (instruction bits [8:6]) that carries an immediate word
- OPC_HALT, 3'd7, opcode that halts the sequencer and is never issued
- TIMEOUT, 15, maximum EXEC cycles allowed without Done (1..255)

- Clock  in  1  single system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- Start  in  1  pulse; in IDLE loads PC from Start_addr and begins execution
- Start_addr  in  ADDR_W  first instruction address
- Step_mode  in  1  1 = pause after every completed instruction
- Step  in  1  pulse; in PAUSE resumes for exactly one instruction
- Stop  in  1  level; honoured at the next instruction boundary
- Rom_addr  out  ADDR_W  ROM address, combinational from state and PC
- Rom_data  in  16  ROM read data, valid one cycle after Rom_addr
- DIN  out  16  processor data input
- Run  out  1  processor Run, one-cycle pulse per instruction
- Done  in  1  processor Done
- Busy  out  1  high in any state except IDLE
- Halted  out  1  sticky; set on a HALT fetch, cleared by Start
- Timeout_err  out  1  sticky; set on Done timeout, cleared by Start
- PC  out  ADDR_W  current instruction address
- Instr_count  out  16  instructions completed since Start; wraps 16'hFFFF->0

## Operation
- States: IDLE, FETCH, DECODE, IMM, ISSUE, EXEC, PAUSE.
- IDLE: Rom_addr = PC. On Start: PC <= Start_addr, Instr_count <= 0, clear Halted and Timeout_err, go to FETCH. Step is ignored.
- FETCH: Rom_addr = PC. Go to DECODE.
- DECODE: latch Rom_data into the instr register. Rom_addr = PC+1 (wrapping).
  - If instr[8:6] == OPC_HALT: set Halted, go to IDLE, no Run.
  - Else if instr[8:6] == OPC_MVI: go to IMM.
  - Else: go to ISSUE.
- IMM: latch Rom_data into the imm register. Go to ISSUE.
- ISSUE: DIN = instr, Run = 1 for this cycle only. Clear the timeout counter. Go to EXEC.
- EXEC: DIN = imm for MVI, otherwise instr. Run = 0. Timeout counter increments each cycle.
  - On Done = 1: PC <= PC+2 for MVI, PC+1 otherwise (modulo 2^ADDR_W); Instr_count++.
  - Next state after Done: IDLE if Stop; PAUSE if Step_mode; else FETCH.
  - If the counter reaches TIMEOUT with no Done: set Timeout_err, go to IDLE, PC unchanged, count unchanged.
- PAUSE: Step -> FETCH. Stop -> IDLE. If both are high, Stop wins. Clearing Step_mode in PAUSE does not self-resume; Step or Stop is still required.
- DIN = 16'h0000 in IDLE, FETCH, DECODE, IMM and PAUSE.
- Start while Busy is ignored. Stop is not an abort: an in-flight instruction always completes or times out.
- Done outside EXEC is ignored.
- MVI at address 2^ADDR_W-1 fetches its immediate from address 0; next PC = 1.

## Timing
- Reset (async assert, sync-safe release) sets:
  - state = IDLE, PC = 0, DIN = 0, Run = 0
  - Busy = 0, Halted = 0, Timeout_err = 0, Instr_count = 0
  - instr and imm registers = 0
- Start sampled at edge 0 -> FETCH in cycle 1 -> DECODE in cycle 2.
  - Non-MVI: ISSUE (Run = 1) in cycle 3.
  - MVI: IMM in cycle 3, ISSUE in cycle 4.
- Earliest Done is the first EXEC cycle (processor T1). MV/MVI loop = 4/5 cycles per instruction; ADD/SUB add the processor's extra T-steps.
- Reset asserted mid-instruction: immediate return to IDLE with the reset values above; Run drops asynchronously.
- Busy, Halted, Timeout_err, PC and Instr_count are registered. Rom_addr and DIN are decoded from registered state only, so no input-to-output combinational path exists.

## Test plan
- ROM[0] = MVI R0 (16'h0040), ROM[1] = 16'h0005, ROM[2] = HALT (16'h01C0); Start_addr = 0, Done pulsed in the first EXEC cycle:
  - Run high in cycle 4; DIN = 16'h0040 in cycle 4, 16'h0005 in cycle 5.
  - Then PC = 2, Halted = 1, Busy = 0, Instr_count = 1.
- ADD (16'h0081) with Done delayed 3 cycles into EXEC:
  - exactly one Run pulse; DIN = 16'h0081 throughout EXEC; PC advances by 1.
- Step_mode = 1 with a three-instruction program:
  - sequencer parks in PAUSE after each Done.
  - each Step pulse yields exactly one Run; Instr_count goes 1, 2, 3.
- Done held low, TIMEOUT = 15:
  - Timeout_err set after 15 EXEC cycles; Busy = 0; PC and count unchanged.
  - a subsequent Start clears Timeout_err.
- ADDR_W = 5, Start_addr = 31, ROM[31] = MVI, ROM[0] = 16'h1234:
  - DIN = 16'h1234 in EXEC; PC = 1 afterwards.
- Stop raised during EXEC: Done is still honoured, then IDLE with no further Run. Resetn pulsed low during EXEC: Run = 0 immediately, all outputs at reset values.
